// File: rtl/complex_div.sv
// rtl/complex_div.sv - sequential Q4.4 complex divider q = (a + j*aj) / (b + j*bj)
// Define COMPLEX_DIV_ROUND_EN for round-half-away-from-zero results (one extra loop cycle).
module complex_div #(
   parameter int DW = 8,
   parameter int QB = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] aj,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] bj,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] c,
   output logic [DW-1:0] cj,
   output logic          dz
);

`ifdef COMPLEX_DIV_ROUND_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif
   localparam int PW = 2 * DW;       // Q8.8 product width
   localparam int FB = DW / 2;       // fractional bits of the Q4.4 result
   localparam int NS = QB + RB;      // restoring-loop iterations
   localparam int W  = PW + NS + 1;  // remainder / shifted-divisor width
   localparam int CW = $clog2(NS) + 1;
   localparam int MW = QB + 1;       // result magnitude with room for the rounding carry
   localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, OUT} state_t;

   state_t               state_q, state_d;
   logic signed [DW-1:0] a_q, a_d, aj_q, aj_d, b_q, b_d, bj_q, bj_d;
   logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
   logic                 ovf_re_q, ovf_re_d, ovf_im_q, ovf_im_d;
   logic [W-1:0]         rem_re_q, rem_re_d, rem_im_q, rem_im_d, dsh_q, dsh_d;
   logic [NS-1:0]        quo_re_q, quo_re_d, quo_im_q, quo_im_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 in_ready_q, in_ready_d, out_valid_q, out_valid_d, dz_q, dz_d;
   logic [DW-1:0]        c_q, c_d, cj_q, cj_d;

   logic signed [PW-1:0] p_ab, p_ajbj, p_ajb, p_abj, p_bb, p_bjbj;
   logic signed [PW:0]   num_re, num_im;
   logic [PW-1:0]        den, mag_re, mag_im;
   logic [W-1:0]         dvd_re, dvd_im, den_w;
   logic                 bit_re, bit_im;
   logic [NS-1:0]        qn_re, qn_im;

   function automatic logic [MW-1:0] round_mag(input logic [NS-1:0] q);
`ifdef COMPLEX_DIV_ROUND_EN
      logic [NS:0] t;
      t = {1'b0, q} + {{NS{1'b0}}, 1'b1};
      return t[NS:1];
`else
      return {1'b0, q};
`endif
   endfunction

   function automatic logic [DW-1:0] saturate(input logic neg, input logic ovf,
                                              input logic [MW-1:0] mag);
      logic [DW-1:0] r;
      if (mag == '0 && !ovf) r = '0;
      else if (!neg)         r = (ovf || mag > MW'(SMAX))  ? SMAX : mag[DW-1:0];
      else                   r = (ovf || mag >= MW'(SMIN)) ? SMIN : -mag[DW-1:0];
      return r;
   endfunction

   always_comb begin
      p_ab   = PW'(a_q)  * PW'(b_q);
      p_ajbj = PW'(aj_q) * PW'(bj_q);
      p_ajb  = PW'(aj_q) * PW'(b_q);
      p_abj  = PW'(a_q)  * PW'(bj_q);
      p_bb   = PW'(b_q)  * PW'(b_q);
      p_bjbj = PW'(bj_q) * PW'(bj_q);
      num_re = {p_ab[PW-1], p_ab} + {p_ajbj[PW-1], p_ajbj};
      num_im = {p_ajb[PW-1], p_ajb} - {p_abj[PW-1], p_abj};
      den    = $unsigned(p_bb) + $unsigned(p_bjbj);
      mag_re = num_re[PW] ? PW'(-num_re) : num_re[PW-1:0];
      mag_im = num_im[PW] ? PW'(-num_im) : num_im[PW-1:0];
      // Q8.8 / Q8.8 is a plain ratio; pre-shift so the quotient lands in Q4.4 (plus half bit)
      dvd_re = W'(mag_re) << (FB + RB);
      dvd_im = W'(mag_im) << (FB + RB);
      den_w  = W'(den);
      bit_re = rem_re_q >= dsh_q;
      bit_im = rem_im_q >= dsh_q;
      qn_re  = {quo_re_q[NS-2:0], bit_re};
      qn_im  = {quo_im_q[NS-2:0], bit_im};
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      aj_d        = aj_q;
      b_d         = b_q;
      bj_d        = bj_q;
      neg_re_d    = neg_re_q;
      neg_im_d    = neg_im_q;
      ovf_re_d    = ovf_re_q;
      ovf_im_d    = ovf_im_q;
      rem_re_d    = rem_re_q;
      rem_im_d    = rem_im_q;
      dsh_d       = dsh_q;
      quo_re_d    = quo_re_q;
      quo_im_d    = quo_im_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      dz_d        = dz_q;
      c_d         = c_q;
      cj_d        = cj_q;
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               a_d        = a;
               aj_d       = aj;
               b_d        = b;
               bj_d       = bj;
               in_ready_d = 1'b0;
               state_d    = MUL;
            end
         end
         MUL: begin
            neg_re_d = num_re[PW];
            neg_im_d = num_im[PW];
            ovf_re_d = dvd_re >= (den_w << NS);
            ovf_im_d = dvd_im >= (den_w << NS);
            rem_re_d = dvd_re;
            rem_im_d = dvd_im;
            dsh_d    = den_w << (NS - 1);
            quo_re_d = '0;
            quo_im_d = '0;
            cnt_d    = '0;
            if (den == '0) begin
               dz_d        = 1'b1;
               c_d         = '0;
               cj_d        = '0;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               state_d = DIV;
            end
         end
         DIV: begin
            if (bit_re) rem_re_d = rem_re_q - dsh_q;
            if (bit_im) rem_im_d = rem_im_q - dsh_q;
            quo_re_d = qn_re;
            quo_im_d = qn_im;
            dsh_d    = dsh_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(NS - 1)) begin
               dz_d        = 1'b0;
               c_d         = saturate(neg_re_q, ovf_re_q, round_mag(qn_re));
               cj_d        = saturate(neg_im_q, ovf_im_q, round_mag(qn_im));
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         aj_q        <= '0;
         b_q         <= '0;
         bj_q        <= '0;
         neg_re_q    <= 1'b0;
         neg_im_q    <= 1'b0;
         ovf_re_q    <= 1'b0;
         ovf_im_q    <= 1'b0;
         rem_re_q    <= '0;
         rem_im_q    <= '0;
         dsh_q       <= '0;
         quo_re_q    <= '0;
         quo_im_q    <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         dz_q        <= 1'b0;
         c_q         <= '0;
         cj_q        <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         aj_q        <= aj_d;
         b_q         <= b_d;
         bj_q        <= bj_d;
         neg_re_q    <= neg_re_d;
         neg_im_q    <= neg_im_d;
         ovf_re_q    <= ovf_re_d;
         ovf_im_q    <= ovf_im_d;
         rem_re_q    <= rem_re_d;
         rem_im_q    <= rem_im_d;
         dsh_q       <= dsh_d;
         quo_re_q    <= quo_re_d;
         quo_im_q    <= quo_im_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         dz_q        <= dz_d;
         c_q         <= c_d;
         cj_q        <= cj_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign c         = c_q;
   assign cj        = cj_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_complex_div.sv
// tb/tb_complex_div.sv - directed and randomized checks of complex_div against a reference model
// Honours COMPLEX_DIV_ROUND_EN for expected rounding and latency.
module tb_complex_div;
   localparam int QB = 8;
`ifdef COMPLEX_DIV_ROUND_EN
   localparam int LAT = QB + 3;
   localparam logic [7:0] RND_P = 8'h03;
   localparam logic [7:0] RND_N = 8'hFD;
`else
   localparam int LAT = QB + 2;
   localparam logic [7:0] RND_P = 8'h02;
   localparam logic [7:0] RND_N = 8'hFE;
`endif

   logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, dz;
   logic [7:0] a, aj, b, bj, c, cj;
   int         vectors = 0;
   int         miscompares = 0;
   int         ncyc = 0;

   complex_div #(.DW(8), .QB(QB)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .aj(aj), .b(b), .bj(bj),
      .out_valid(out_valid), .out_ready(out_ready), .c(c), .cj(cj), .dz(dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // Quotient of the real-valued ratio num/den scaled to Q4.4, then clamped to the signed range
   function automatic logic [7:0] model_quot(input int num, input int den);
      int m, q, v;
      m = (num < 0) ? -num : num;
`ifdef COMPLEX_DIV_ROUND_EN
      q = (32 * m + den) / (2 * den);
`else
      q = (16 * m) / den;
`endif
      v = (num < 0) ? -q : q;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   // Returns {dz, c, cj}
   function automatic logic [16:0] model(input logic [7:0] ta, taj, tb, tbj);
      int ia, iaj, ib, ibj, den;
      ia  = $signed(ta);
      iaj = $signed(taj);
      ib  = $signed(tb);
      ibj = $signed(tbj);
      den = ib * ib + ibj * ibj;
      if (den == 0) return {1'b1, 16'h0000};
      return {1'b0, model_quot(ia * ib + iaj * ibj, den), model_quot(iaj * ib - ia * ibj, den)};
   endfunction

   typedef struct { logic [16:0] r; int acc; } exp_t;
   exp_t exp_q[$];
   bit   seen_first = 0;

   always @(negedge clk) begin
      ncyc = ncyc + 1;
      if (!rst_n) begin
         exp_q.delete();
         seen_first = 0;
      end else begin
         chk("in_ready_vs_busy", in_ready, exp_q.size() == 0);
         if (exp_q.size() != 0 && !seen_first && !out_valid && ncyc - exp_q[0].acc == LAT + 1)
            chk("out_valid_late", out_valid, 1);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("out_valid_unexpected", out_valid, 0);
            end else begin
               chk("c", c, exp_q[0].r[15:8]);
               chk("cj", cj, exp_q[0].r[7:0]);
               chk("dz", dz, exp_q[0].r[16]);
               if (!seen_first)
                  chk("latency", ncyc - exp_q[0].acc, exp_q[0].r[16] ? 2 : LAT);
               seen_first = 1;
            end
            if (out_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               seen_first = 0;
            end
         end
         if (in_valid && in_ready) exp_q.push_back('{model(a, aj, b, bj), ncyc});
      end
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [7:0] ta, taj, tb, tbj);
      int n;
      a = ta; aj = taj; b = tb; bj = tbj;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 100);
      if (!out_valid) chk("wait_out_timeout", out_valid, 1);
   endtask

   typedef struct { logic [7:0] a, aj, b, bj, c, cj; logic dz; } dvec_t;
   dvec_t dv[10];

   initial begin
      int k;
      logic [16:0] e;
      dv = '{
         '{8'h10, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0},
         '{8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'hF0, 1'b0},
         '{8'h35, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1},
         '{8'h7F, 8'h00, 8'h01, 8'h00, 8'h7F, 8'h00, 1'b0},
         '{8'h80, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 1'b0},
         '{8'h10, 8'h00, 8'h60, 8'h00, RND_P, 8'h00, 1'b0},
         '{8'hF0, 8'h00, 8'h60, 8'h00, RND_N, 8'h00, 1'b0},
         '{8'h80, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00, 1'b0},
         '{8'h40, 8'h00, 8'h08, 8'h00, 8'h7F, 8'h00, 1'b0},
         '{8'h10, 8'h20, 8'h10, 8'h10, 8'h18, 8'h08, 1'b0}
      };
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; aj = '0; b = '0; bj = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_c", c, 8'h00);
      chk("rst_cj", cj, 8'h00);
      chk("rst_dz", dz, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (dv[i]) begin
         e = model(dv[i].a, dv[i].aj, dv[i].b, dv[i].bj);
         chk("model_c", e[15:8], dv[i].c);
         chk("model_cj", e[7:0], dv[i].cj);
         chk("model_dz", e[16], dv[i].dz);
         send(dv[i].a, dv[i].aj, dv[i].b, dv[i].bj);
         wait_out(k);
         chk("dir_c", c, dv[i].c);
         chk("dir_cj", cj, dv[i].cj);
         chk("dir_dz", dz, dv[i].dz);
         chk("dir_latency", k, dv[i].dz ? 2 : LAT);
         @(posedge clk);
         #1;
      end

      // Backpressure with competing operands offered
      out_ready = 1'b0;
      send(8'h10, 8'h00, 8'h60, 8'h00);
      wait_out(k);
      #1;
      in_valid = 1'b1; a = 8'h55; aj = 8'h22; b = 8'h11; bj = 8'h33;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_c", c, RND_P);
         chk("bp_cj", cj, 8'h00);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset while dividing
      send(8'h20, 8'h00, 8'h10, 8'h00);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_c", c, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (15) begin
         @(negedge clk);
         chk("mid_rst_no_out", out_valid, 0);
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 4000; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 3) != 0);
         a  = 8'($urandom);
         aj = 8'($urandom);
         case ($urandom_range(0, 7))
            0: begin b = 8'h00; bj = 8'h00; end
            1: begin b = 8'($urandom_range(0, 4)) - 8'd2; bj = 8'($urandom_range(0, 4)) - 8'd2; end
            default: begin b = 8'($urandom); bj = 8'($urandom); end
         endcase
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3 * (LAT + 3)) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_in_ready", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/complex_div.md
Name: complex_div

Overview:
- Sequential fixed-point complex divider, q = (a + j·aj) / (b + j·bj), on signed Q4.4 operands in [3:-4] format (8-bit, LSB = 0.0625).
- Inverse counterpart of the combinational complex_mul used by the FFT datapath.
- Serves IFFT/normalisation and equaliser paths that must undo a twiddle or channel product.
- Iterative restoring division with valid/ready handshakes on both sides; one operation in flight.

Parameters:
- DW, 8: operand/result width, fixed Q4.4 (only 8 is supported).
- QB, 8: quotient magnitude bits produced by the restoring loop.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  divider can accept operands
- a  in  8  numerator real, signed Q4.4
- aj  in  8  numerator imaginary, signed Q4.4
- b  in  8  denominator real, signed Q4.4
- bj  in  8  denominator imaginary, signed Q4.4
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- c  out  8  quotient real, signed Q4.4
- cj  out  8  quotient imaginary, signed Q4.4
- dz  out  1  divide-by-zero flag, qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 after release; out_valid=0; c=cj=0x00; dz=0; iteration counter=0.
- FSM states: IDLE -> MUL -> DIV -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready, register a, aj, b, bj and go to MUL.
- MUL (1 cycle):
  - num_re = a·b + aj·bj and num_im = aj·b − a·bj, as 17-bit signed Q8.8.
  - den = b² + bj², as 16-bit unsigned Q8.8 (max 32768).
  - Store the sign and 16-bit magnitude of each numerator.
  - Dividend = magnitude<<4 (20-bit).
  - Pre-check: if dividend ≥ den<<QB, set the overflow flag for that component.
  - If den==0, set dz and skip to OUT with c=cj=0x00.
- DIV (QB cycles):
  - Two restoring dividers share den and run in parallel, one quotient bit per cycle, MSB first.
  - Counter runs 0..QB-1.
- OUT:
  - out_valid=1 holding c, cj, dz; in_ready=0.
  - Leave to IDLE on out_ready; out_valid drops the next cycle.
- Result formation:
  - Truncation toward zero on magnitude; apply sign.
  - Positive: magnitude>127 or overflow -> 0x7F.
  - Negative: magnitude>128 or overflow -> 0x80; exactly 128 -> 0x80.
  - Zero magnitude -> 0x00 regardless of sign.
- Latency: handshake cycle T -> out_valid first high at T+QB+2 (T+10 by default); dz case at T+2.
- Throughput: one result per QB+3 cycles minimum; a new operand is accepted the cycle after the OUT handshake.
- Backpressure: with out_ready=0, c/cj/dz/out_valid stay stable indefinitely; in_ready stays 0.
- in_valid is ignored outside IDLE.
- Reset mid-operation: aborts immediately; pending result discarded; no out_valid after release until a new handshake.
- Simultaneous out_ready and in_valid in OUT: in_valid is not accepted in that cycle.

Optional Feature:
- Macro: COMPLEX_DIV_ROUND_EN.
- Defined:
  - DIV runs QB+1 cycles; the extra LSB is a half bit.
  - Magnitude is rounded half away from zero before sign and saturation.
  - Latency becomes T+QB+3.
- Undefined: truncation toward zero; latency T+QB+2.

Test Plan:
- (1.0+j0)/(1.0+j0): a=0x10 aj=0x00 b=0x10 bj=0x00 -> c=0x10 cj=0x00 dz=0, out_valid exactly 10 cycles after accept.
- (1+j)/(j): a=0x10 aj=0x10 b=0x00 bj=0x10 -> c=0x10 cj=0xF0.
- Divide by zero: b=bj=0x00, a=0x35 -> c=cj=0x00, dz=1, out_valid at T+2.
- Saturation:
  - a=0x7F b=0x01 aj=bj=0 -> c=0x7F.
  - a=0x80 b=0x01 -> c=0x80.
- Rounding:
  - a=0x10 b=0x60 -> c=0x02 (no macro) / 0x03 (macro).
  - a=0xF0 b=0x60 -> c=0xFE / 0xFD.
- Backpressure and reset:
  - Hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0.
  - Assert rst_n=0 during DIV -> out_valid=0, c=0x00 immediately, in_ready=1 after release.
